cache_responder: RTL and testbench

- Slave-side endpoint of the cache bus: connects to the `slave` modport of `cache_interface` and answers core load/store accesses.
- Functional data comes from an internal word-addressed backing RAM.
- A direct-mapped tag/valid array models hit/miss timing: misses stall the master for a fixed refill latency before `hit` asserts.
- Used as the default data/instruction memory for simulation and small FPGA builds.

---
 rtl/cache_responder_if.sv | 22 ++
 rtl/cache_responder.sv | 95 +++++++++
 tb/tb_cache_responder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cache_responder_if.sv
// cache_responder_if: access-size type and cache bus interface shared by masters and cache_responder
// addr/access/write/rd_size/wr_size/wr_data flow master->slave; rd_data/hit flow slave->master.
package cache_pkg;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} cache_access_size_t;
endpackage

interface cache_interface #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32
);
  import cache_pkg::*;
  logic [ADDR_SIZE-1:0] addr;
  logic access;
  logic write;
  cache_access_size_t rd_size;
  cache_access_size_t wr_size;
  logic [WORD_SIZE-1:0] wr_data;
  logic [WORD_SIZE-1:0] rd_data;
  logic hit;
  modport master(output addr, access, write, rd_size, wr_size, wr_data, input rd_data, hit);
  modport slave(input addr, access, write, rd_size, wr_size, wr_data, output rd_data, hit);
endinterface

// File: rtl/cache_responder.sv
// cache_responder: cache-bus slave backed by a word RAM, with a direct-mapped tag array modelling miss latency
// Ports: clk_i clock; reset_i async active-high reset; bus cache_interface.slave (addr/access/write/
// rd_size/wr_size/wr_data in, rd_data/hit out). With CACHE_RESPONDER_STATS_EN defined, adds
// saturating hit_count/miss_count outputs.
module cache_responder
  import cache_pkg::*;
#(
  parameter int ADDR_SIZE    = 32,
  parameter int WORD_SIZE    = 32,
  parameter int NUM_LINES    = 16,
  parameter int MEM_WORDS    = 4096,
  parameter int MISS_LATENCY = 4
) (
  input logic clk_i,
  input logic reset_i,
  cache_interface.slave bus
`ifdef CACHE_RESPONDER_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int IW = $clog2(NUM_LINES);
  localparam int MW = $clog2(MEM_WORDS);
  localparam int TW = ADDR_SIZE - 2 - IW;
  localparam int CW = $clog2(MISS_LATENCY + 1);
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic [NUM_LINES-1:0] valid;
  logic [TW-1:0] tags [NUM_LINES];
  logic [WORD_SIZE-1:0] mem [MEM_WORDS];
  logic [1:0] off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [MW-1:0] widx;
  logic [WORD_SIZE-1:0] word, wdata, rd;
  logic [3:0] be;
  logic hit, install;
  assign off = bus.addr[1:0];
  assign idx = bus.addr[2 +: IW];
  assign tag = bus.addr[ADDR_SIZE-1 -: TW];
  assign widx = bus.addr[2 +: MW];
  assign word = mem[widx];
  assign install = state == FILL && cnt == '0;
  assign bus.hit = hit;
  assign bus.rd_data = rd;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? ((bus.access && !hit) ? FILL : IDLE) : (install ? IDLE : FILL);
  always_comb begin
    hit = bus.access && state == IDLE && valid[idx] && tags[idx] == tag;
    rd = bus.rd_size == BYTE ? WORD_SIZE'(word[{off, 3'b000} +: 8]) :
         bus.rd_size == HALF ? WORD_SIZE'(word[{off[1], 4'b0000} +: 16]) : word;
    be = bus.wr_size == BYTE ? 4'b0001 << off :
         bus.wr_size == HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = bus.wr_size == BYTE ? {4{bus.wr_data[7:0]}} :
            bus.wr_size == HALF ? {2{bus.wr_data[15:0]}} : bus.wr_data;
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      cnt <= '0;
      valid <= '0;
    end else begin
      if (state == IDLE && state_n == FILL) cnt <= CW'(MISS_LATENCY - 1);
      else if (state == FILL && cnt != '0) cnt <= cnt - 1'b1;
      if (install) valid[fill_idx] <= 1'b1;
    end
  // Reset forces IDLE asynchronously, so an aborted refill never reaches install.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && state_n == FILL) begin
      fill_idx <= idx;
      fill_tag <= tag;
    end
    if (install) tags[fill_idx] <= fill_tag;
  end
  always_ff @(posedge clk_i)
    if (bus.access && bus.write && hit)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
`ifdef CACHE_RESPONDER_STATS_EN
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (hit && hit_count != '1) hit_count <= hit_count + 1'b1;
      if (state == IDLE && state_n == FILL && miss_count != '1) miss_count <= miss_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_cache_responder.sv
// tb_cache_responder: directed stimulus with a queue scoreboard checking hit/rd_data on every access cycle
module tb_cache_responder;
  import cache_pkg::*;
  localparam int LAT = 4;
  typedef struct {
    logic eh;
    logic chk;
    logic [31:0] ed;
    string nm;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  exp_t q[$];
  exp_t e;
`ifdef CACHE_RESPONDER_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif
  cache_interface #(.ADDR_SIZE(32), .WORD_SIZE(32)) bus_if ();
  cache_responder #(.MISS_LATENCY(LAT)) dut (
    .clk_i(clk),
    .reset_i(rst),
    .bus(bus_if.slave)
`ifdef CACHE_RESPONDER_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );
  always #5 clk = ~clk;
  function automatic void push(input logic eh, input logic chk, input logic [31:0] ed, input string nm);
    q.push_back('{eh, chk, ed, nm});
  endfunction
  task automatic step(input logic acc, input logic wr, input logic [31:0] a, input cache_access_size_t sz,
                      input logic [31:0] wd, input logic eh, input logic chk, input logic [31:0] ed, input string nm);
    @(posedge clk);
    #1;
    bus_if.access = acc;
    bus_if.write = wr;
    bus_if.addr = a;
    bus_if.rd_size = sz;
    bus_if.wr_size = sz;
    bus_if.wr_data = wd;
    if (acc) push(eh, chk, ed, nm);
  endtask
  task automatic miss_hit(input logic wr, input logic [31:0] a, input cache_access_size_t sz, input logic [31:0] wd,
                          input logic chk, input logic [31:0] ed, input string nm);
    repeat (LAT + 1) step(1, wr, a, sz, wd, 0, chk, ed, {nm, "_miss"});
    step(1, wr, a, sz, wd, 1, chk, ed, {nm, "_hit"});
  endtask
  task automatic pulse_reset();
    @(posedge clk);
    #1;
    bus_if.access = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask
  always @(negedge clk)
    if (bus_if.access) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_access: got hit=%0b, expected no access", bus_if.hit);
      end else begin
        e = q.pop_front();
        if (bus_if.hit !== e.eh || (e.chk && bus_if.rd_data !== e.ed)) begin
          errors++;
          $display("FAIL %s: got hit=%0b data=%h, expected hit=%0b data=%h%s", e.nm, bus_if.hit,
                   bus_if.rd_data, e.eh, e.ed, e.chk ? "" : " (data unchecked)");
        end
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    bus_if.access = 0;
    bus_if.write = 0;
    bus_if.addr = 0;
    bus_if.rd_size = WORD;
    bus_if.wr_size = WORD;
    bus_if.wr_data = 0;
    #1 rst = 1;
    bus_if.access = 1;
    bus_if.addr = 32'h10;
    push(0, 0, 0, "reset_hit");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    bus_if.access = 0;
    // preload RAM through a store, then reset so the tag array is cold again
    miss_hit(1, 32'h10, WORD, 32'hDEADBEEF, 0, 0, "preload");
    pulse_reset();
    miss_hit(0, 32'h10, WORD, 0, 1, 32'hDEADBEEF, "cold");
    step(1, 0, 32'h10, WORD, 0, 1, 1, 32'hDEADBEEF, "repeat_hit");
    step(1, 1, 32'h13, BYTE, 32'hAA, 1, 0, 0, "st_byte");
    step(1, 0, 32'h10, WORD, 0, 1, 1, 32'hAAADBEEF, "ld_word");
    step(1, 0, 32'h12, HALF, 0, 1, 1, 32'h0000AAAD, "ld_half12");
    step(1, 0, 32'h11, BYTE, 0, 1, 1, 32'h000000BE, "ld_byte11");
    step(1, 0, 32'h13, HALF, 0, 1, 1, 32'h0000AAAD, "ld_half13");
    step(1, 0, 32'h13, WORD, 0, 1, 1, 32'hAAADBEEF, "ld_word13");
    step(1, 0, 32'h10, BYTE, 0, 1, 1, 32'h000000EF, "ld_byte10");
    step(1, 0, 32'h10, HALF, 0, 1, 1, 32'h0000BEEF, "ld_half10");
    step(0, 0, 0, WORD, 0, 0, 0, 0, "idle");
    miss_hit(1, 32'h50, WORD, 32'h12345678, 0, 0, "conf_store");
    step(1, 0, 32'h50, WORD, 0, 1, 1, 32'h12345678, "conf_load");
    miss_hit(0, 32'h10, WORD, 0, 1, 32'hAAADBEEF, "evicted");
    step(1, 0, 32'h20, WORD, 0, 0, 0, 0, "mf_miss20");
    step(1, 0, 32'h20, WORD, 0, 0, 0, 0, "mf_fill1");
    repeat (3) step(1, 0, 32'h24, WORD, 0, 0, 0, 0, "mf_fill24");
    miss_hit(0, 32'h24, WORD, 0, 0, 0, "mf_24");
    step(1, 0, 32'h20, WORD, 0, 1, 0, 0, "mf_20_resident");
    step(1, 0, 32'h30, WORD, 0, 0, 0, 0, "rm_miss");
    step(1, 0, 32'h30, WORD, 0, 0, 0, 0, "rm_fill1");
    @(posedge clk);
    #1;
    rst = 1;
    push(0, 0, 0, "rm_in_reset");
    @(posedge clk);
    #1;
    rst = 0;
    push(0, 0, 0, "rm_remiss");
    repeat (LAT) step(1, 0, 32'h30, WORD, 0, 0, 0, 0, "rm_fill");
    step(1, 0, 32'h30, WORD, 0, 1, 0, 0, "rm_hit");
    miss_hit(0, 32'h10, WORD, 0, 1, 32'hAAADBEEF, "post_reset10");
`ifdef CACHE_RESPONDER_STATS_EN
    pulse_reset();
    chk32("hit_count_reset", hit_count, 0);
    chk32("miss_count_reset", miss_count, 0);
    step(1, 0, 32'h40, WORD, 0, 0, 0, 0, "st_miss40");
    repeat (LAT) step(0, 0, 0, WORD, 0, 0, 0, 0, "");
    step(1, 0, 32'h44, WORD, 0, 0, 0, 0, "st_miss44");
    repeat (LAT) step(0, 0, 0, WORD, 0, 0, 0, 0, "");
    step(1, 0, 32'h48, WORD, 0, 0, 0, 0, "st_miss48");
    repeat (LAT) step(0, 0, 0, WORD, 0, 0, 0, 0, "");
    step(1, 0, 32'h40, WORD, 0, 1, 0, 0, "st_hit40");
    step(1, 0, 32'h44, WORD, 0, 1, 0, 0, "st_hit44");
    step(1, 0, 32'h48, WORD, 0, 1, 0, 0, "st_hit48");
    step(1, 0, 32'h40, WORD, 0, 1, 0, 0, "st_hit40b");
    step(1, 0, 32'h44, WORD, 0, 1, 0, 0, "st_hit44b");
    step(0, 0, 0, WORD, 0, 0, 0, 0, "");
    chk32("hit_count", hit_count, 5);
    chk32("miss_count", miss_count, 3);
    pulse_reset();
    chk32("hit_count_rst2", hit_count, 0);
    chk32("miss_count_rst2", miss_count, 0);
`endif
    step(0, 0, 0, WORD, 0, 0, 0, 0, "");
    @(negedge clk);
    chk32("scoreboard_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
